// File: rtl/spi_master_seq_if.sv
// spi_master_seq_if: request, FIFO-read and SPI pin bundle for the SPI write sequencer.
// Build option: define SPI_READ_EN to add the MISO capture signals (spi_miso, rx_data, rx_valid).
interface spi_master_seq_if #(
    parameter int DSIZE = 8,
    parameter int LEN_W = 4
);
    logic             start;
    logic [DSIZE-1:0] addr_in;
    logic [LEN_W-1:0] len_in;
    logic             fifo_empty;
    logic             fifo_rd_en;
    logic [DSIZE-1:0] fifo_data;
    logic             spi_cs;
    logic             spi_sclk;
    logic             spi_mosi_out;
    logic             busy;
    logic             done;
    logic             underrun;
`ifdef SPI_READ_EN
    logic             spi_miso;
    logic [DSIZE-1:0] rx_data;
    logic             rx_valid;

    modport master (
        input  start, addr_in, len_in, fifo_empty, fifo_data, spi_miso,
        output fifo_rd_en, spi_cs, spi_sclk, spi_mosi_out, busy, done, underrun,
        output rx_data, rx_valid
    );

    modport slave (
        output start, addr_in, len_in, fifo_empty, fifo_data, spi_miso,
        input  fifo_rd_en, spi_cs, spi_sclk, spi_mosi_out, busy, done, underrun,
        input  rx_data, rx_valid
    );
`else
    modport master (
        input  start, addr_in, len_in, fifo_empty, fifo_data,
        output fifo_rd_en, spi_cs, spi_sclk, spi_mosi_out, busy, done, underrun
    );

    modport slave (
        output start, addr_in, len_in, fifo_empty, fifo_data,
        input  fifo_rd_en, spi_cs, spi_sclk, spi_mosi_out, busy, done, underrun
    );
`endif
endinterface

// File: rtl/spi_master_seq.sv
// spi_master_seq: frames one SPI mode-0 write per request (address byte, then len_in
// data bytes pulled from the upstream FIFO), with an explicit FSM and FIFO handshake.
// Build option: define SPI_READ_EN to capture MISO during data bytes into rx_data/rx_valid.
module spi_master_seq #(
    parameter int DSIZE   = 8,
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 4
) (
    input  logic             spi_clk,
    input  logic             n_reset,
    spi_master_seq_if.master bus
);
    localparam int             BCW      = (DSIZE > 2) ? $clog2(DSIZE) : 1;
    localparam logic [7:0]     DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(DSIZE - 1);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_FETCH, S_LOAD, S_DATA, S_HOLD} state_t;

    state_t           r_state;
    logic [7:0]       r_div;
    logic [BCW-1:0]   r_bit;
    logic [LEN_W-1:0] r_bytes;
    logic [DSIZE-1:0] r_shift;
    logic             r_cs;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_busy;
    logic             r_done;
    logic             r_underrun;
    logic             w_div_end;
`ifdef SPI_READ_EN
    logic [DSIZE-1:0] r_rx_shift;
    logic [DSIZE-1:0] r_rx_data;
    logic             r_rx_valid;
`endif

    assign w_div_end = (r_div == DIV_LAST);

    // The read strobe has to be seen by the FIFO in the FETCH cycle itself so that
    // its data is valid during LOAD; it is therefore decoded from the registered state.
    assign bus.fifo_rd_en   = (r_state == S_FETCH) && !bus.fifo_empty;
    assign bus.spi_cs       = r_cs;
    assign bus.spi_sclk     = r_sclk;
    assign bus.spi_mosi_out = r_mosi;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.underrun     = r_underrun;
`ifdef SPI_READ_EN
    assign bus.rx_data      = r_rx_data;
    assign bus.rx_valid     = r_rx_valid;
`endif

    // Frame sequencer: state, sclk divider/phase, bit/byte counters and all pin registers.
    always_ff @(posedge spi_clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state    <= S_IDLE;
            r_div      <= '0;
            r_bit      <= '0;
            r_bytes    <= '0;
            r_shift    <= '0;
            r_cs       <= 1'b1;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
`ifdef SPI_READ_EN
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef SPI_READ_EN
            r_rx_valid <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state    <= S_ADDR;
                        r_cs       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_shift    <= bus.addr_in;
                        r_mosi     <= bus.addr_in[DSIZE-1];
                        r_bytes    <= bus.len_in;
                        r_underrun <= 1'b0;
                        r_div      <= '0;
                        r_bit      <= '0;
                        r_sclk     <= 1'b0;
                    end
                end
                S_ADDR, S_DATA: begin
                    if (!w_div_end) begin
                        r_div <= r_div + 8'd1;
                    end else begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            // Low phase done: rising edge, the slave samples MOSI here.
                            r_sclk <= 1'b1;
`ifdef SPI_READ_EN
                            if (r_state == S_DATA)
                                r_rx_shift <= {r_rx_shift[DSIZE-2:0], bus.spi_miso};
`endif
                        end else begin
                            // High phase done: falling edge, next bit goes out on MOSI.
                            r_sclk <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_state <= (r_bytes == '0) ? S_HOLD : S_FETCH;
`ifdef SPI_READ_EN
                                if (r_state == S_DATA) begin
                                    r_rx_data  <= r_rx_shift;
                                    r_rx_valid <= 1'b1;
                                end
`endif
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_shift <= r_shift << 1;
                                r_mosi  <= r_shift[DSIZE-2];
                            end
                        end
                    end
                end
                S_FETCH: begin
                    // An empty FIFO stalls the frame here with sclk held low.
                    if (!bus.fifo_empty) r_state <= S_LOAD;
                    else                 r_underrun <= 1'b1;
                end
                S_LOAD: begin
                    r_shift <= bus.fifo_data;
                    r_mosi  <= bus.fifo_data[DSIZE-1];
                    r_bytes <= r_bytes - 1'b1;
                    r_bit   <= '0;
                    r_div   <= '0;
                    r_state <= S_DATA;
                end
                S_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= S_IDLE;
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_mosi  <= 1'b0;
                    end else begin
                        r_div <= r_div + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_seq.sv
// tb_spi_master_seq: table-driven and randomized frames for spi_master_seq against a
// byte/bit-level frame model, plus hand sequences for stall, reset abort and back-to-back starts.
module tb_spi_master_seq;
    localparam int DSIZE = 8;
    localparam int D     = 2;
    localparam int LEN_W = 4;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    spi_master_seq_if #(.DSIZE(DSIZE), .LEN_W(LEN_W)) bus ();
    spi_master_seq_if #(.DSIZE(DSIZE), .LEN_W(LEN_W)) bus1 ();

    spi_master_seq #(.DSIZE(DSIZE), .CLK_DIV(D), .LEN_W(LEN_W)) u_dut (
        .spi_clk (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    spi_master_seq #(.DSIZE(DSIZE), .CLK_DIV(1), .LEN_W(LEN_W)) u_dut1 (
        .spi_clk (clk),
        .n_reset (n_reset),
        .bus     (bus1)
    );

    typedef struct {
        logic [7:0]  addr;
        int          len;
        logic [31:0] data;     // byte i at data[8*i +: 8]
        int          exp_cs;   // cs-low cycles
        int          exp_rises;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  fifo_q[$];
    bit          fifo_pend;
    int          cyc, cs_cnt, cs_falls, rd_cnt, rd_viol, hi_viol, busy_viol, done_cnt;
    int          last_done_cyc, last_fall_cyc, n_rises;
    logic [63:0] got_v;
    logic        prev_sclk, prev_mosi, prev_cs;
`ifdef SPI_READ_EN
    int          rx_cnt, rx_early;
    logic [7:0]  rx_last;
    logic [7:0]  miso_pat = 8'h00;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon_reset();
        cyc = 0; cs_cnt = 0; cs_falls = 0; rd_cnt = 0; rd_viol = 0; hi_viol = 0;
        busy_viol = 0; done_cnt = 0; last_done_cyc = 0; last_fall_cyc = 0;
        n_rises = 0; got_v = '0;
        prev_sclk = bus.spi_sclk; prev_mosi = bus.spi_mosi_out; prev_cs = bus.spi_cs;
`ifdef SPI_READ_EN
        rx_cnt = 0; rx_early = 0; rx_last = '0;
`endif
    endtask

    // One clock: update FIFO/MISO stimulus at the falling edge, then observe 1 unit later.
    task automatic step();
        @(negedge clk);
        if (fifo_pend && fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
        else                                bus.fifo_data = 8'($urandom);
        bus.fifo_empty = (fifo_q.size() == 0);
`ifdef SPI_READ_EN
        if (n_rises >= DSIZE && n_rises < 2*DSIZE) bus.spi_miso = miso_pat[2*DSIZE-1-n_rises];
        else                                       bus.spi_miso = 1'($urandom);
`endif
        #1;
        cyc++;
        if (!bus.spi_cs) cs_cnt++;
        if (!bus.spi_cs && prev_cs) begin cs_falls++; last_fall_cyc = cyc; end
        if (!bus.spi_cs && !bus.busy) busy_viol++;
        if (bus.spi_sclk && !prev_sclk) begin
            got_v = {got_v[62:0], bus.spi_mosi_out};
            n_rises++;
        end
        if (bus.spi_sclk && prev_sclk && (bus.spi_mosi_out !== prev_mosi)) hi_viol++;
        if (bus.done) begin done_cnt++; last_done_cyc = cyc; end
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            if (bus.fifo_empty) rd_viol++;
        end
`ifdef SPI_READ_EN
        if (bus.rx_valid) begin
            rx_cnt++;
            rx_last = bus.rx_data;
            if (n_rises <= DSIZE) rx_early++;
        end
`endif
        fifo_pend = bus.fifo_rd_en;
        prev_sclk = bus.spi_sclk;
        prev_mosi = bus.spi_mosi_out;
        prev_cs   = bus.spi_cs;
    endtask

    // Run one stall-free frame and compare against the frame model.
    task automatic run_frame(input logic [7:0] a, input int n, input logic [31:0] d,
                             input int exp_cs, input int exp_rises, input string tag);
        logic [63:0] exp_v;
        for (int i = 0; i < n; i++) fifo_q.push_back(d[8*i +: 8]);
        mon_reset();
        bus.addr_in = a;
        bus.len_in  = LEN_W'(n);
        bus.start   = 1'b1;
        step();
        bus.start   = 1'b0;
        while (done_cnt == 0 && cyc < 1000) step();
        repeat (3) step();
        exp_v = 64'(a);
        for (int i = 0; i < n; i++) exp_v = (exp_v << 8) | 64'(d[8*i +: 8]);
        check($sformatf("%s bits", tag),      got_v,     exp_v);
        check($sformatf("%s rises", tag),     n_rises,   exp_rises);
        check($sformatf("%s cs_low", tag),    cs_cnt,    exp_cs);
        check($sformatf("%s cs_falls", tag),  cs_falls,  1);
        check($sformatf("%s rd_en", tag),     rd_cnt,    n);
        check($sformatf("%s rd_empty", tag),  rd_viol,   0);
        check($sformatf("%s mosi_hi", tag),   hi_viol,   0);
        check($sformatf("%s busy_cs", tag),   busy_viol, 0);
        check($sformatf("%s done", tag),      done_cnt,  1);
        check($sformatf("%s end", tag),
              {bus.busy, bus.spi_cs, bus.spi_sclk, bus.spi_mosi_out, bus.underrun}, 5'b01000);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[5];
        logic [7:0]  b1;
        logic        p1;
        int          c1, d1, r1, n1, stall_bad, dfirst;
        logic [7:0]  ra;
        int          rn;
        logic [31:0] rd;

        vecs[0] = '{8'hA5, 2, 32'h0000FF3C, 102, 24};
        vecs[1] = '{8'h00, 0, 32'h00000000,  34,  8};
        vecs[2] = '{8'hFF, 1, 32'h00000081,  68, 16};
        vecs[3] = '{8'h5C, 3, 32'h00A55AC3, 136, 32};
        vecs[4] = '{8'h81, 4, 32'h01807F00, 170, 40};

        n_reset = 1'b1;
        bus.start = 1'b0; bus.addr_in = '0; bus.len_in = '0; bus.fifo_empty = 1'b1; bus.fifo_data = '0;
        bus1.start = 1'b0; bus1.addr_in = '0; bus1.len_in = '0; bus1.fifo_empty = 1'b1; bus1.fifo_data = '0;
`ifdef SPI_READ_EN
        bus.spi_miso = 1'b0; bus1.spi_miso = 1'b0;
`endif
        fifo_pend = 1'b0;

        // Reset values, checked before any clock edge.
        #2 n_reset = 1'b0;
        #1;
        check("rst outputs",
              {bus.spi_cs, bus.spi_sclk, bus.spi_mosi_out, bus.fifo_rd_en, bus.busy, bus.done, bus.underrun},
              7'b1000000);
        check("rst cs div1", bus1.spi_cs, 1'b1);
        step(); step();
        n_reset = 1'b1;
        step();

        // CLK_DIV=1, address-only frame 0x46.
        b1 = '0; p1 = bus1.spi_sclk; c1 = 0; d1 = 0; r1 = 0; n1 = 0;
        bus1.addr_in = 8'h46; bus1.len_in = '0; bus1.start = 1'b1;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk); #1;
            bus1.start = 1'b0;
            if (!bus1.spi_cs) c1++;
            if (bus1.spi_sclk && !p1) begin b1 = {b1[6:0], bus1.spi_mosi_out}; n1++; end
            p1 = bus1.spi_sclk;
            if (bus1.done) d1++;
            if (bus1.fifo_rd_en) r1++;
        end
        check("div1 bits",   b1, 8'h46);
        check("div1 rises",  n1, 8);
        check("div1 cs_low", c1, 17);
        check("div1 done",   d1, 1);
        check("div1 rd_en",  r1, 0);
        check("div1 busy",   bus1.busy, 1'b0);

        // Table vectors.
        for (int i = 0; i < 5; i++)
            run_frame(vecs[i].addr, vecs[i].len, vecs[i].data, vecs[i].exp_cs, vecs[i].exp_rises,
                      $sformatf("vec%0d", i));

        // Randomized frames against the length formula and the byte stream model.
        for (int k = 0; k < 6; k++) begin
            ra = 8'($urandom);
            rn = $urandom_range(0, 4);
            rd = $urandom;
            run_frame(ra, rn, rd, 2*DSIZE*D + rn*(2 + 2*DSIZE*D) + D, DSIZE*(rn + 1),
                      $sformatf("rnd%0d", k));
        end

        // FIFO empty when the data byte is due: stall, underrun, then normal completion.
        mon_reset();
        bus.addr_in = 8'hC6; bus.len_in = LEN_W'(1); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        stall_bad = 0;
        while (cyc < 43) begin
            step();
            if (cyc >= 34 && (bus.spi_sclk || bus.spi_cs || bus.fifo_rd_en || !bus.underrun)) stall_bad++;
        end
        check("stall hold",  stall_bad, 0);
        check("stall no_rd", rd_cnt, 0);
        fifo_q.push_back(8'h96);
        while (done_cnt == 0 && cyc < 1000) step();
        repeat (3) step();
        check("stall bits",     got_v, 64'hC696);
        check("stall cs_low",   cs_cnt, 79);
        check("stall rd_en",    rd_cnt, 1);
        check("stall rd_empty", rd_viol, 0);
        check("stall done",     done_cnt, 1);
        check("stall sticky",   bus.underrun, 1'b1);

        // Next start clears underrun; reset in the data byte aborts without done.
        fifo_q.push_back(8'h69);
        mon_reset();
        bus.addr_in = 8'h3C; bus.len_in = LEN_W'(1); bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        check("underrun clr", bus.underrun, 1'b0);
        while (cyc < 45) step();
        check("abort in data", n_rises, 11);
        n_reset = 1'b0;
        #1;
        check("abort pins", {bus.spi_cs, bus.spi_sclk, bus.busy, bus.spi_mosi_out, bus.done}, 5'b10000);
        repeat (4) step();
        check("abort no_done", done_cnt, 0);
        fifo_q.delete();
        fifo_pend = 1'b0;
        n_reset = 1'b1;
        step();
        run_frame(8'h3C, 1, 32'h00000069, 68, 16, "post_rst");

        // start held high: back-to-back frames, no extra frames from start during busy.
        mon_reset();
        bus.addr_in = 8'h99; bus.len_in = '0; bus.start = 1'b1;
        dfirst = -1;
        while (done_cnt < 2 && cyc < 400) begin
            step();
            if (done_cnt == 1 && dfirst < 0) dfirst = last_done_cyc;
        end
        bus.start = 1'b0;
        repeat (6) step();
        check("b2b frames", cs_falls, 2);
        check("b2b done",   done_cnt, 2);
        check("b2b gap",    last_fall_cyc, dfirst + 1);
        check("b2b idle",   {bus.spi_cs, bus.busy}, 2'b10);

`ifdef SPI_READ_EN
        miso_pat = 8'h5A;
        run_frame(8'hE7, 1, 32'h00000024, 68, 16, "read");
        check("rx count", rx_cnt, 1);
        check("rx data",  rx_last, 8'h5A);
        check("rx early", rx_early, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
